// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU opcodes, register-zero constant, ID/EX record and bubble helpers.
package mips_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0001;
   localparam logic [3:0] ALU_ADDU = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0011;
   localparam logic [3:0] ALU_SUBU = 4'b0100;
   localparam logic [3:0] ALU_AND  = 4'b0101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_XOR  = 4'b0111;
   localparam logic [3:0] ALU_NOR  = 4'b1000;
   localparam logic [3:0] ALU_SLT  = 4'b1001;
   localparam logic [3:0] ALU_SLL  = 4'b1010;
   localparam logic [3:0] ALU_SRL  = 4'b1011;
   localparam logic [3:0] ALU_SRA  = 4'b1100;

   localparam logic [3:0] ALUCTR_NOP = ALU_ADD;
   localparam logic [4:0] REG_ZERO   = 5'd0;

   typedef struct packed {
      logic        valid;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  aluctr;
      logic [4:0]  shamt;
      logic        wreg;
      logic [4:0]  wdst;
      logic [31:0] pc;
   } ex_reg_t;

   localparam ex_reg_t EX_BUBBLE = '{valid: 1'b0, a: 32'd0, b: 32'd0, aluctr: ALUCTR_NOP,
                                     shamt: 5'd0, wreg: 1'b0, wdst: 5'd0, pc: 32'd0};

   function automatic ex_reg_t bubble_rec(input logic [3:0] nop);
      ex_reg_t r;
      r        = EX_BUBBLE;
      r.aluctr = nop;
      return r;
   endfunction

   // $0 is hard-wired, so a read of it can never depend on an in-flight write.
   function automatic logic src_match(input logic used, input logic [4:0] src,
                                      input logic wr, input logic [4:0] dst);
      return used && (src != REG_ZERO) && wr && (src == dst);
   endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational RAW detector: ID sources against EX, MEM and (optionally) WB destinations.
module hazard_unit
   import mips_pkg::*;
#(
   parameter bit WB_BYPASS = 1'b1
) (
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_rs_used,
   input  logic       id_rt_used,
   input  logic       ex_valid,
   input  logic       ex_wreg,
   input  logic [4:0] ex_wdst,
   input  logic       exm_wreg,
   input  logic [4:0] exm_wdst,
   input  logic       mwb_wreg,
   input  logic [4:0] mwb_wdst,
   output logic       hazard
);

   logic w_ex_wr;
   logic w_wb_wr;
   logic w_rs_hit;
   logic w_rt_hit;

   assign w_ex_wr = ex_valid & ex_wreg;
   // With write-before-read register file the WB value is already visible to ID.
   assign w_wb_wr = WB_BYPASS ? 1'b0 : mwb_wreg;

   assign w_rs_hit = src_match(id_rs_used, id_rs, w_ex_wr,  ex_wdst)
                   | src_match(id_rs_used, id_rs, exm_wreg, exm_wdst)
                   | src_match(id_rs_used, id_rs, w_wb_wr,  mwb_wdst);

   assign w_rt_hit = src_match(id_rt_used, id_rt, w_ex_wr,  ex_wdst)
                   | src_match(id_rt_used, id_rt, exm_wreg, exm_wdst)
                   | src_match(id_rt_used, id_rt, w_wb_wr,  mwb_wdst);

   assign hazard = id_valid & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/id_ex_interlock.sv
// ID/EX pipeline register with RAW interlock, memory hold and branch flush.
// Optional ID_EX_PERF_CNT_EN adds hazard-bubble and hold-cycle counters.
module id_ex_interlock #(
   parameter bit         WB_BYPASS  = 1'b1,
   parameter logic [3:0] ALUCTR_NOP = mips_pkg::ALUCTR_NOP
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_rs_used,
   input  logic        id_rt_used,
   input  logic [31:0] id_rdata_a,
   input  logic [31:0] id_rdata_b,
   input  logic [31:0] id_imm,
   input  logic        id_use_imm,
   input  logic [3:0]  id_aluctr,
   input  logic [4:0]  id_shamt,
   input  logic        id_wreg,
   input  logic [4:0]  id_wdst,
   input  logic [31:0] id_pc,
   input  logic        exm_wreg,
   input  logic [4:0]  exm_wdst,
   input  logic        mwb_wreg,
   input  logic [4:0]  mwb_wdst,
   input  logic        mem_hold,
   input  logic        flush,
   output logic        stall,
   output logic        ex_valid,
   output logic [31:0] ex_a,
   output logic [31:0] ex_b,
   output logic [3:0]  ex_aluctr,
   output logic [4:0]  ex_shamt,
   output logic        ex_wreg,
   output logic [4:0]  ex_wdst,
   output logic [31:0] ex_pc
`ifdef ID_EX_PERF_CNT_EN
  ,output logic [31:0] perf_bubble_cnt,
   output logic [31:0] perf_hold_cnt
`endif
);

   localparam mips_pkg::ex_reg_t L_BUBBLE = mips_pkg::bubble_rec(ALUCTR_NOP);

   logic              w_hazard;
   mips_pkg::ex_reg_t w_load;
   mips_pkg::ex_reg_t r_ex;

   hazard_unit #(.WB_BYPASS(WB_BYPASS)) u_hazard (
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_rs_used (id_rs_used),
      .id_rt_used (id_rt_used),
      .ex_valid   (r_ex.valid),
      .ex_wreg    (r_ex.wreg),
      .ex_wdst    (r_ex.wdst),
      .exm_wreg   (exm_wreg),
      .exm_wdst   (exm_wdst),
      .mwb_wreg   (mwb_wreg),
      .mwb_wdst   (mwb_wdst),
      .hazard     (w_hazard)
   );

   // A flush kills the dependent instruction, so there is nothing left to wait for.
   assign stall = mem_hold | (w_hazard & ~flush);

   always_comb begin
      w_load        = L_BUBBLE;
      w_load.valid  = id_valid;
      w_load.a      = id_rdata_a;
      w_load.b      = id_use_imm ? id_imm : id_rdata_b;
      w_load.aluctr = id_aluctr;
      w_load.shamt  = id_shamt;
      w_load.wreg   = id_wreg & id_valid;
      w_load.wdst   = id_wdst;
      w_load.pc     = id_pc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                r_ex <= L_BUBBLE;
      else if (mem_hold)         r_ex <= r_ex;
      else if (flush | w_hazard) r_ex <= L_BUBBLE;
      else                       r_ex <= w_load;
   end

   assign ex_valid  = r_ex.valid;
   assign ex_a      = r_ex.a;
   assign ex_b      = r_ex.b;
   assign ex_aluctr = r_ex.aluctr;
   assign ex_shamt  = r_ex.shamt;
   assign ex_wreg   = r_ex.wreg;
   assign ex_wdst   = r_ex.wdst;
   assign ex_pc     = r_ex.pc;

`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] r_bubble_cnt;
   logic [31:0] r_hold_cnt;

   // Only interlock bubbles count; flush bubbles are a branch cost, not a hazard cost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bubble_cnt <= 32'd0;
         r_hold_cnt   <= 32'd0;
      end else if (mem_hold) begin
         r_hold_cnt   <= r_hold_cnt + 32'd1;
      end else if (w_hazard && !flush) begin
         r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
   end

   assign perf_bubble_cnt = r_bubble_cnt;
   assign perf_hold_cnt   = r_hold_cnt;
`endif

endmodule

// File: tb/tb_id_ex_interlock.sv
// Bench for id_ex_interlock: vector table with expected-record queue, plus reset and RAW-depth sequences.
module tb_id_ex_interlock;
   import mips_pkg::*;

   localparam int LD = 0;
   localparam int BB = 1;
   localparam int HD = 2;
   localparam int OP_ADD  = int'(ALU_ADD);
   localparam int OP_ADDU = int'(ALU_ADDU);
   localparam int OP_SUB  = int'(ALU_SUB);
   localparam int OP_SUBU = int'(ALU_SUBU);
   localparam int OP_AND  = int'(ALU_AND);
   localparam int OP_OR   = int'(ALU_OR);
   localparam int OP_XOR  = int'(ALU_XOR);
   localparam int OP_NOR  = int'(ALU_NOR);
   localparam int OP_SLL  = int'(ALU_SLL);

   typedef struct {
      int unsigned v, rs, rt, rsu, rtu, a, b, imm, ui, op, sh, wr, wd, pc;
      int unsigned xw, xd, ww, wwd, hold, fl;
      int unsigned st1, st0, chk0;
      int          kind;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        id_valid = 1'b0, id_rs_used = 1'b0, id_rt_used = 1'b0, id_use_imm = 1'b0, id_wreg = 1'b0;
   logic [4:0]  id_rs = '0, id_rt = '0, id_shamt = '0, id_wdst = '0, exm_wdst = '0, mwb_wdst = '0;
   logic [31:0] id_rdata_a = '0, id_rdata_b = '0, id_imm = '0, id_pc = '0;
   logic [3:0]  id_aluctr = 4'b0001;
   logic        exm_wreg = 1'b0, mwb_wreg = 1'b0, mem_hold = 1'b0, flush = 1'b0;

   logic        stall1, ex_valid1, ex_wreg1, stall0, ex_valid0, ex_wreg0;
   logic [31:0] ex_a1, ex_b1, ex_pc1, ex_a0, ex_b0, ex_pc0;
   logic [3:0]  ex_aluctr1, ex_aluctr0;
   logic [4:0]  ex_shamt1, ex_wdst1, ex_shamt0, ex_wdst0;
`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] pb1, ph1, pb0, ph0;
`endif

   int total = 0;
   int bad   = 0;
   ex_reg_t sbq[$];
   ex_reg_t cur;
   vec_t    tv[17];

   always #5 clk = ~clk;

   id_ex_interlock #(.WB_BYPASS(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rdata_a(id_rdata_a), .id_rdata_b(id_rdata_b),
      .id_imm(id_imm), .id_use_imm(id_use_imm), .id_aluctr(id_aluctr), .id_shamt(id_shamt),
      .id_wreg(id_wreg), .id_wdst(id_wdst), .id_pc(id_pc), .exm_wreg(exm_wreg), .exm_wdst(exm_wdst),
      .mwb_wreg(mwb_wreg), .mwb_wdst(mwb_wdst), .mem_hold(mem_hold), .flush(flush), .stall(stall1),
      .ex_valid(ex_valid1), .ex_a(ex_a1), .ex_b(ex_b1), .ex_aluctr(ex_aluctr1), .ex_shamt(ex_shamt1),
      .ex_wreg(ex_wreg1), .ex_wdst(ex_wdst1), .ex_pc(ex_pc1)
`ifdef ID_EX_PERF_CNT_EN
     ,.perf_bubble_cnt(pb1), .perf_hold_cnt(ph1)
`endif
   );

   id_ex_interlock #(.WB_BYPASS(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rdata_a(id_rdata_a), .id_rdata_b(id_rdata_b),
      .id_imm(id_imm), .id_use_imm(id_use_imm), .id_aluctr(id_aluctr), .id_shamt(id_shamt),
      .id_wreg(id_wreg), .id_wdst(id_wdst), .id_pc(id_pc), .exm_wreg(exm_wreg), .exm_wdst(exm_wdst),
      .mwb_wreg(mwb_wreg), .mwb_wdst(mwb_wdst), .mem_hold(mem_hold), .flush(flush), .stall(stall0),
      .ex_valid(ex_valid0), .ex_a(ex_a0), .ex_b(ex_b0), .ex_aluctr(ex_aluctr0), .ex_shamt(ex_shamt0),
      .ex_wreg(ex_wreg0), .ex_wdst(ex_wdst0), .ex_pc(ex_pc0)
`ifdef ID_EX_PERF_CNT_EN
     ,.perf_bubble_cnt(pb0), .perf_hold_cnt(ph0)
`endif
   );

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
      end
   endtask

   function automatic ex_reg_t bub();
      ex_reg_t e;
      e = '{valid: 1'b0, a: 32'd0, b: 32'd0, aluctr: 4'b0001, shamt: 5'd0, wreg: 1'b0, wdst: 5'd0, pc: 32'd0};
      return e;
   endfunction

   function automatic ex_reg_t exp_load(input vec_t t);
      ex_reg_t e;
      e.valid  = 1'(t.v);
      e.a      = t.a;
      e.b      = (t.ui != 0) ? t.imm : t.b;
      e.aluctr = 4'(t.op);
      e.shamt  = 5'(t.sh);
      e.wreg   = 1'(t.wr & t.v);
      e.wdst   = 5'(t.wd);
      e.pc     = t.pc;
      return e;
   endfunction

   task automatic apply(input vec_t t);
      id_valid = 1'(t.v);   id_rs = 5'(t.rs);        id_rt = 5'(t.rt);
      id_rs_used = 1'(t.rsu); id_rt_used = 1'(t.rtu);
      id_rdata_a = t.a;     id_rdata_b = t.b;        id_imm = t.imm;    id_use_imm = 1'(t.ui);
      id_aluctr = 4'(t.op); id_shamt = 5'(t.sh);     id_wreg = 1'(t.wr); id_wdst = 5'(t.wd);
      id_pc = t.pc;
      exm_wreg = 1'(t.xw);  exm_wdst = 5'(t.xd);     mwb_wreg = 1'(t.ww); mwb_wdst = 5'(t.wwd);
      mem_hold = 1'(t.hold); flush = 1'(t.fl);
   endtask

   task automatic cmp_ex(input int idx, input ex_reg_t e);
      chk("ex_valid",  idx, 32'(ex_valid1),  32'(e.valid));
      chk("ex_a",      idx, ex_a1,           e.a);
      chk("ex_b",      idx, ex_b1,           e.b);
      chk("ex_aluctr", idx, 32'(ex_aluctr1), 32'(e.aluctr));
      chk("ex_shamt",  idx, 32'(ex_shamt1),  32'(e.shamt));
      chk("ex_wreg",   idx, 32'(ex_wreg1),   32'(e.wreg));
      chk("ex_wdst",   idx, 32'(ex_wdst1),   32'(e.wdst));
      chk("ex_pc",     idx, ex_pc1,          e.pc);
   endtask

   task automatic run_row(input vec_t t, input int idx);
      ex_reg_t e;
      @(negedge clk);
      apply(t);
      #1;
      chk("stall", idx, 32'(stall1), t.st1);
      if (t.chk0 != 0) chk("stall_wb0", idx, 32'(stall0), t.st0);
      case (t.kind)
         LD:      e = exp_load(t);
         BB:      e = bub();
         default: e = cur;
      endcase
      cur = e;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) chk("sbq_empty", idx, 32'd1, 32'd0);
      else cmp_ex(idx, sbq.pop_front());
   endtask

   task automatic set_id(input int rs, input int rt, input int wd, input int unsigned pc);
      id_valid = 1'b1; id_rs = 5'(rs); id_rt = 5'(rt); id_rs_used = 1'b1; id_rt_used = 1'b1;
      id_rdata_a = 32'h1000 + 32'(rs); id_rdata_b = 32'h2000 + 32'(rt); id_use_imm = 1'b0;
      id_aluctr = ALU_ADDU; id_shamt = 5'd0; id_wreg = 1'b1; id_wdst = 5'(wd); id_pc = pc;
   endtask

   initial begin
      int n1, n0, b1, b0;
      //          v rs rt su tu a             b             imm           ui op       sh wr wd pc          xw xd ww wwd hd fl st1 st0 c0 kind
      tv[0]  = '{1, 1, 2, 1, 1, 32'h11,       32'h22,       0,            0, OP_ADDU, 0, 1, 3, 32'h100,    0, 0, 0, 0, 0, 0, 0, 0, 1, LD};
      tv[1]  = '{1, 4, 5, 1, 1, 32'h44,       32'h55,       0,            0, OP_ADDU, 0, 1, 6, 32'h104,    0, 0, 0, 0, 0, 0, 0, 0, 1, LD};
      tv[2]  = '{1, 7, 8, 1, 0, 32'h77,       32'hDEAD,     32'hFFFFFFF0, 1, OP_ADD,  0, 1, 8, 32'h108,    1, 3, 0, 0, 0, 0, 0, 0, 1, LD};
      tv[3]  = '{1, 0, 9, 1, 1, 32'h0,        32'h99,       0,            0, OP_SLL,  4, 1, 10, 32'h10C,   1, 0, 1, 3, 0, 0, 0, 0, 1, LD};
      tv[4]  = '{1, 0, 10, 0, 0, 32'h0,       32'h0,        32'h12340000, 1, OP_OR,   0, 1, 10, 32'h110,   1, 8, 1, 6, 0, 0, 0, 0, 1, LD};
      tv[5]  = '{0, 10, 10, 1, 1, 32'hAAAA,   32'hBBBB,     0,            0, OP_SUB,  3, 1, 12, 32'h114,   1, 10, 1, 8, 0, 0, 0, 0, 1, LD};
      tv[6]  = '{1, 10, 0, 1, 0, 32'h1,       32'h2,        0,            0, OP_ADDU, 0, 1, 13, 32'h118,   1, 10, 0, 0, 0, 0, 1, 1, 1, BB};
      tv[7]  = '{1, 10, 0, 1, 0, 32'h1,       32'h2,        0,            0, OP_ADDU, 0, 1, 13, 32'h118,   1, 10, 0, 0, 0, 1, 0, 0, 1, BB};
      tv[8]  = '{1, 1, 2, 1, 1, 32'h123,      32'h456,      0,            0, OP_XOR,  0, 1, 14, 32'h200,   0, 0, 0, 0, 0, 0, 0, 0, 1, LD};
      tv[9]  = '{1, 14, 14, 1, 1, 32'h5,      32'h6,        0,            0, OP_SUBU, 0, 1, 15, 32'h204,   0, 0, 0, 0, 1, 0, 1, 1, 1, HD};
      tv[10] = '{1, 14, 14, 1, 1, 32'h5,      32'h6,        0,            0, OP_SUBU, 0, 1, 15, 32'h204,   0, 0, 0, 0, 1, 0, 1, 1, 1, HD};
      tv[11] = '{1, 14, 14, 1, 1, 32'h5,      32'h6,        0,            0, OP_SUBU, 0, 1, 15, 32'h204,   0, 0, 0, 0, 1, 1, 1, 1, 1, HD};
      tv[12] = '{1, 14, 14, 1, 1, 32'h5,      32'h6,        0,            0, OP_SUBU, 0, 1, 15, 32'h204,   0, 0, 0, 0, 0, 0, 1, 1, 1, BB};
      tv[13] = '{1, 14, 14, 1, 1, 32'h5,      32'h6,        0,            0, OP_SUBU, 0, 1, 15, 32'h204,   1, 14, 0, 0, 0, 0, 1, 1, 1, BB};
      tv[14] = '{1, 14, 14, 1, 1, 32'h5,      32'h6,        0,            0, OP_SUBU, 0, 1, 15, 32'h204,   0, 0, 1, 14, 0, 0, 0, 1, 1, LD};
      tv[15] = '{1, 1, 15, 1, 1, 32'h9,       32'h8,        0,            0, OP_AND,  0, 0, 0, 32'h208,    0, 0, 0, 0, 0, 0, 1, 0, 0, BB};
      tv[16] = '{1, 2, 3, 1, 1, 32'h2,        32'h3,        0,            0, OP_NOR,  0, 1, 16, 32'h20C,   0, 0, 0, 0, 0, 0, 0, 0, 0, LD};

      cur = bub();
      #12;
      chk("rst_ex_valid", 0, 32'(ex_valid1), 32'd0);
      chk("rst_ex_aluctr", 0, 32'(ex_aluctr1), 32'h1);
      chk("rst_stall", 0, 32'(stall1), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) run_row(tv[i], i);

`ifdef ID_EX_PERF_CNT_EN
      chk("perf_hold", 0, ph1, 32'd3);
      chk("perf_bubble", 0, pb1, 32'd4);
`endif

      // asynchronous reset while a valid instruction sits in EX
      @(negedge clk);
      chk("pre_rst_valid", 1, 32'(ex_valid1), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 1, 32'(ex_valid1), 32'd0);
      chk("arst_a", 1, ex_a1, 32'd0);
      chk("arst_b", 1, ex_b1, 32'd0);
      chk("arst_aluctr", 1, 32'(ex_aluctr1), 32'h1);
      chk("arst_shamt", 1, 32'(ex_shamt1), 32'd0);
      chk("arst_wreg", 1, 32'(ex_wreg1), 32'd0);
      chk("arst_wdst", 1, 32'(ex_wdst1), 32'd0);
      chk("arst_pc", 1, ex_pc1, 32'd0);
      chk("arst_stall", 1, 32'(stall1), 32'd0);
`ifdef ID_EX_PERF_CNT_EN
      chk("arst_perf_hold", 1, ph1, 32'd0);
      chk("arst_perf_bubble", 1, pb1, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      cur = bub();
      run_row(tv[0], 100);

      // back-to-back RAW: addu $3,$1,$2 then subu $4,$3,$5 with downstream driven as the pipe would
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      exm_wreg = 1'b0; exm_wdst = 5'd0; mwb_wreg = 1'b0; mwb_wdst = 5'd0; mem_hold = 1'b0; flush = 1'b0;
      set_id(1, 2, 3, 32'h300);
      @(posedge clk);
      #1;
      chk("raw_first_valid", 2, 32'(ex_valid1), 32'd1);
      n1 = 0; n0 = 0; b1 = 0; b0 = 0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         set_id(3, 5, 4, 32'h304);
         exm_wreg = (c == 2); exm_wdst = (c == 2) ? 5'd3 : 5'd0;
         mwb_wreg = (c == 3); mwb_wdst = (c == 3) ? 5'd3 : 5'd0;
         #1;
         if (stall1) n1++;
         if (stall0) n0++;
         @(posedge clk);
         #1;
         if (!ex_valid1 && ex_aluctr1 == 4'b0001) b1++;
         if (!ex_valid0 && ex_aluctr0 == 4'b0001) b0++;
      end
      chk("raw_stall_bypass", 3, 32'(n1), 32'd2);
      chk("raw_bubble_bypass", 3, 32'(b1), 32'd2);
      chk("raw_stall_nobypass", 3, 32'(n0), 32'd3);
      chk("raw_bubble_nobypass", 3, 32'(b0), 32'd3);
      chk("raw_ex_a", 3, ex_a1, 32'h1003);
      chk("raw_ex_b", 3, ex_b1, 32'h2005);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_ex_interlock.md
Name: id_ex_interlock

Overview:
- ID/EX pipeline register for the non-forwarding 5-stage MIPS pipeline, directly upstream of the ALU.
- Latches decoded operands, ALU control and shift amount.
- Detects RAW hazards against EX, MEM and WB destinations and inserts bubbles while freezing IF/ID.
- Supports a memory-hold freeze and a branch flush.

Parameters:
- WB_BYPASS, 1: 1 = register file writes before it reads in the same cycle, so the WB destination is excluded from the hazard check; 0 = WB is checked.
- ALUCTR_NOP, 4'b0001: ALU control driven during a bubble (add). 0000 is never driven.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  5 each  source register numbers
- id_rs_used, id_rt_used  in  1 each  source is actually read
- id_rdata_a, id_rdata_b  in  32 each  register file read data
- id_imm  in  32  extended immediate
- id_use_imm  in  1  select id_imm for B
- id_aluctr  in  4  ALU operation code
- id_shamt  in  5  inst[10:6]
- id_wreg  in  1  instruction writes a register
- id_wdst  in  5  destination register
- id_pc  in  32  instruction PC
- exm_wreg, exm_wdst  in  1, 5  EX/MEM write-back info
- mwb_wreg, mwb_wdst  in  1, 5  MEM/WB write-back info
- mem_hold  in  1  downstream freeze
- flush  in  1  branch taken; kill the ID instruction
- stall  out  1  freeze PC and IF/ID
- ex_valid  out  1
- ex_a, ex_b  out  32 each
- ex_aluctr  out  4
- ex_shamt  out  5
- ex_wreg  out  1
- ex_wdst  out  5
- ex_pc  out  32

Behaviour:
- Reset (async, rst_n=0): every ex_* output is 0 except ex_aluctr=ALUCTR_NOP. stall=0.
- Reset deassertion mid-operation: the first edge after release loads normally. No residual hazard state survives reset.
- Source match rule: a source matches a destination if it is used, it is nonzero, and it equals that destination with its write flag set.
  - EX destination = ex_valid & ex_wreg, ex_wdst.
  - MEM destination = exm_wreg, exm_wdst.
  - WB destination = mwb_wreg, mwb_wdst, checked only when WB_BYPASS=0.
- Register 0 never creates a hazard.
- hazard = id_valid & (rs match | rt match). It is combinational.
- stall = mem_hold | (hazard & ~flush). It is combinational.
- Per-edge priority, highest first:
  1. mem_hold: all ex_* registers hold.
  2. flush: load a bubble.
  3. hazard: load a bubble.
  4. Otherwise: load ID.
- Bubble contents: ex_valid=0, ex_wreg=0, ex_wdst=0, ex_a=0, ex_b=0, ex_shamt=0, ex_pc=0, ex_aluctr=ALUCTR_NOP.
- Normal load (latency 1 cycle):
  - ex_valid=id_valid
  - ex_a=id_rdata_a
  - ex_b = id_use_imm ? id_imm : id_rdata_b
  - ex_aluctr, ex_shamt, ex_wdst, ex_pc copied from ID
  - ex_wreg = id_wreg & id_valid
- id_valid=0 loads as a bubble-equivalent (ex_valid=0, ex_wreg=0) and never stalls.
- Simultaneous flush and hazard: flush wins, so stall is deasserted.
- Simultaneous mem_hold and flush: hold wins. The flush must be re-presented by its source.
- Bubble depth for a back-to-back dependence: 2 cycles with WB_BYPASS=1, 3 cycles with WB_BYPASS=0.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined, adds two outputs: perf_bubble_cnt [31:0] and perf_hold_cnt [31:0].
  - perf_bubble_cnt increments on each edge where a hazard bubble is loaded. Flush bubbles are not counted.
  - perf_hold_cnt increments on each edge where mem_hold=1.
  - Both are async-reset to 0 and wrap from 32'hFFFFFFFF to 0.
- When undefined, neither port nor any counter logic exists. All other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - ALU opcode constants (add 0001 … sra 1100), including ALUCTR_NOP
  - REG_ZERO = 5'd0
  - a bubble-record constant
- One sub-module, hazard_unit: purely combinational source/destination comparator producing hazard.
- The pipeline register, priority mux and counters stay in the top module.

Test Plan:
1. Reset: rst_n=0 mid-stream with ex_valid=1 → all outputs 0 and ex_aluctr=0001 asynchronously, with no clock edge required.
2. Independent instructions: addu $3,$1,$2 then addu $6,$4,$5, WB_BYPASS=1 → no stall; second instruction reaches EX one cycle later with ex_a/ex_b equal to the read data.
3. RAW through EX then MEM: addu $3,$1,$2 then subu $4,$3,$5, WB_BYPASS=1 → stall=1 for 2 cycles and 2 bubbles (ex_valid=0, aluctr=0001); with WB_BYPASS=0 → 3 bubbles.
4. Register zero and unused source: id_rs=0 with exm_wdst=0 and exm_wreg=1; also a lui with rt_used=0 whose rt matches the EX destination → stall=0 in both cases.
5. Flush during hazard: hazard and flush both 1 → stall=0 and a bubble is loaded. Next cycle, a new non-dependent instruction loads normally.
6. mem_hold for 3 cycles during a hazard → ex_* held, stall=1 throughout. With ID_EX_PERF_CNT_EN defined → perf_hold_cnt=3 and perf_bubble_cnt counts only hazard bubbles.
